ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: EX_STAGE

---
 rtl/ex_stage.sv | 171 +++++++++++++++++
 tb/tb_ex_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, HI/LO and a 32-cycle shift-add MULTU.
// EX/MEM outputs are registered; stall is high while the multiplier iterates.
module ex_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        id_valid,
    input  logic [3:0]  alu_op,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    input  logic [31:0] imm,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        alu_src,
    input  logic        reg_dst,
    input  logic [1:0]  control_wb,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  forward_a,
    input  logic [1:0]  forward_b,
    input  logic [31:0] mem_fwd_data,
    input  logic [31:0] wb_fwd_data,
    output logic        stall,
    output logic [1:0]  ex_control_wb,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic [31:0] ex_alu_result,
    output logic [31:0] ex_write_data,
    output logic [4:0]  ex_write_reg
);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;
    localparam logic [3:0] OP_PASSA = 4'd15;

    state_t      state;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [4:0]  cnt;

    logic [31:0] alu_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [63:0] acc_next;
    logic [4:0]  dst_reg;

    assign stall = (state == MUL_BUSY);

    always_comb begin
        alu_a = read_data_1;
        unique case (forward_a)
            2'b01:   alu_a = wb_fwd_data;
            2'b10:   alu_a = mem_fwd_data;
            default: alu_a = read_data_1;
        endcase
    end

    always_comb begin
        fwd_b = read_data_2;
        unique case (forward_b)
            2'b01:   fwd_b = wb_fwd_data;
            2'b10:   fwd_b = mem_fwd_data;
            default: fwd_b = read_data_2;
        endcase
    end

    assign alu_b   = alu_src ? imm : fwd_b;
    assign dst_reg = reg_dst ? rd : rt;

    always_comb begin
        alu_y = 32'd0;
        unique case (alu_op)
            OP_ADD:   alu_y = alu_a + alu_b;
            OP_SUB:   alu_y = alu_a - alu_b;
            OP_AND:   alu_y = alu_a & alu_b;
            OP_OR:    alu_y = alu_a | alu_b;
            OP_XOR:   alu_y = alu_a ^ alu_b;
            OP_NOR:   alu_y = ~(alu_a | alu_b);
            OP_SLT:   alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU:  alu_y = {31'd0, alu_a < alu_b};
            OP_SLL:   alu_y = alu_b << shamt;
            OP_SRL:   alu_y = alu_b >> shamt;
            OP_SRA:   alu_y = $unsigned($signed(alu_b) >>> shamt);
            OP_LUI:   alu_y = alu_b << 16;
            OP_MULTU: alu_y = 32'd0;
            OP_MFHI:  alu_y = hi;
            OP_MFLO:  alu_y = lo;
            OP_PASSA: alu_y = alu_a;
        endcase
    end

    // LSB-first: multiplicand shifts left as multiplier shifts right
    assign acc_next = acc + (mplier[0] ? mcand : 64'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            hi            <= 32'd0;
            lo            <= 32'd0;
            mcand         <= 64'd0;
            mplier        <= 32'd0;
            acc           <= 64'd0;
            cnt           <= 5'd0;
            ex_control_wb <= 2'd0;
            ex_MemRead    <= 1'b0;
            ex_MemWrite   <= 1'b0;
            ex_alu_result <= 32'd0;
            ex_write_data <= 32'd0;
            ex_write_reg  <= 5'd0;
        end else begin
            ex_control_wb <= 2'd0;
            ex_MemRead    <= 1'b0;
            ex_MemWrite   <= 1'b0;
            ex_alu_result <= 32'd0;
            ex_write_data <= 32'd0;
            ex_write_reg  <= 5'd0;
            unique case (state)
                IDLE: begin
                    if (id_valid && alu_op == OP_MULTU) begin
                        mcand  <= {32'd0, alu_a};
                        mplier <= alu_b;
                        acc    <= 64'd0;
                        cnt    <= 5'd0;
                        state  <= MUL_BUSY;
                    end else if (id_valid) begin
                        ex_control_wb <= control_wb;
                        ex_MemRead    <= MemRead;
                        ex_MemWrite   <= MemWrite;
                        ex_alu_result <= alu_y;
                        ex_write_data <= fwd_b;
                        ex_write_reg  <= dst_reg;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi    <= acc_next[63:32];
                        lo    <= acc_next[31:0];
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, forwarding, MULTU timing, reset abort.
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [3:0]  alu_op;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        alu_src;
    logic        reg_dst;
    logic [1:0]  control_wb;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [31:0] mem_fwd_data;
    logic [31:0] wb_fwd_data;
    logic        stall;
    logic [1:0]  ex_control_wb;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_write_reg;

    int n_tests = 0;
    int n_fail  = 0;

    ex_stage dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .alu_op(alu_op),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .imm(imm), .shamt(shamt), .rt(rt), .rd(rd),
        .alu_src(alu_src), .reg_dst(reg_dst),
        .control_wb(control_wb), .MemRead(MemRead), .MemWrite(MemWrite),
        .forward_a(forward_a), .forward_b(forward_b),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .stall(stall), .ex_control_wb(ex_control_wb),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
        .ex_write_reg(ex_write_reg)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_res"}, ex_alu_result, 32'd0);
        check({tag, "_ctl"}, {27'd0, ex_write_reg}
              | {ex_control_wb, ex_MemRead, ex_MemWrite, 28'd0}
              | {27'd0, 5'd0}, 32'd0);
        check({tag, "_wd"}, ex_write_data, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        id_valid    = 1'b1;
        alu_op      = op;
        read_data_1 = a;
        read_data_2 = b;
        alu_src     = 1'b0;
        forward_a   = 2'b00;
        forward_b   = 2'b00;
    endtask

    int cyc;

    initial begin
        RST = 1'b1; id_valid = 1'b0; alu_op = 4'd0;
        read_data_1 = 32'd0; read_data_2 = 32'd0; imm = 32'd0;
        shamt = 5'd0; rt = 5'd0; rd = 5'd0; alu_src = 1'b0;
        reg_dst = 1'b0; control_wb = 2'd0; MemRead = 1'b0;
        MemWrite = 1'b0; forward_a = 2'd0; forward_b = 2'd0;
        mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
        step();
        step();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check_bubble("rst");
        RST = 1'b0;

        // ADD overflow wraps; controls and rd pass through
        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_1234);
        imm = 32'd1; alu_src = 1'b1; reg_dst = 1'b1;
        rd = 5'd9; rt = 5'd4; control_wb = 2'b10;
        MemRead = 1'b1; MemWrite = 1'b0;
        step();
        check("add_res", ex_alu_result, 32'h8000_0000);
        check("add_wb", {30'd0, ex_control_wb}, 32'd2);
        check("add_mr", {31'd0, ex_MemRead}, 32'd1);
        check("add_mw", {31'd0, ex_MemWrite}, 32'd0);
        check("add_wreg", {27'd0, ex_write_reg}, 32'd9);
        check("add_wdata", ex_write_data, 32'h0000_1234);

        // SUB with forwarded operands, rt destination
        issue(4'd1, 32'hDEAD_0000, 32'hBEEF_0000);
        forward_a = 2'b10; mem_fwd_data = 32'd5;
        forward_b = 2'b01; wb_fwd_data = 32'd3;
        reg_dst = 1'b0; control_wb = 2'b01;
        MemRead = 1'b0; MemWrite = 1'b1;
        step();
        check("sub_res", ex_alu_result, 32'd2);
        check("sub_wdata", ex_write_data, 32'd3);
        check("sub_wreg", {27'd0, ex_write_reg}, 32'd4);
        check("sub_mw", {31'd0, ex_MemWrite}, 32'd1);

        control_wb = 2'b00; MemWrite = 1'b0;
        issue(4'd6, 32'hFFFF_FFFF, 32'd1);
        step();
        check("slt", ex_alu_result, 32'd1);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        step();
        check("sltu", ex_alu_result, 32'd0);
        issue(4'd10, 32'd0, 32'h8000_0000);
        shamt = 5'd4;
        step();
        check("sra", ex_alu_result, 32'hF800_0000);
        issue(4'd9, 32'd0, 32'h8000_0000);
        step();
        check("srl", ex_alu_result, 32'h0800_0000);
        issue(4'd5, 32'h0F0F_0000, 32'h0000_00F0);
        step();
        check("nor", ex_alu_result, 32'hF0F0_FF0F);
        issue(4'd11, 32'd0, 32'd0);
        imm = 32'h0000_ABCD; alu_src = 1'b1;
        step();
        check("lui", ex_alu_result, 32'hABCD_0000);
        issue(4'd15, 32'h1357_9BDF, 32'd0);
        forward_a = 2'b11;
        step();
        check("passa_f11", ex_alu_result, 32'h1357_9BDF);

        id_valid = 1'b0;
        step();
        check_bubble("novalid");

        // MULTU max x max, then MFLO held upstream
        issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("acc_stall", {31'd0, stall}, 32'd0);
        step();
        check_bubble("mul_acc");
        alu_op = 4'd14;
        read_data_1 = 32'd0;
        read_data_2 = 32'd0;
        cyc = 0;
        while (stall && cyc < 40) begin
            if (ex_alu_result !== 32'd0)
                check("mul_busy_bubble", ex_alu_result, 32'd0);
            step();
            cyc++;
        end
        check("stall_cycles", cyc, 32'd32);
        check_bubble("mul_end");
        step();
        check("mflo", ex_alu_result, 32'h0000_0001);
        alu_op = 4'd13;
        step();
        check("mfhi", ex_alu_result, 32'hFFFF_FFFE);

        // reset in the 10th busy cycle aborts and clears HI/LO
        issue(4'd12, 32'd3, 32'd5);
        step();
        for (int i = 1; i < 10; i++) step();
        check("busy10", {31'd0, stall}, 32'd1);
        RST = 1'b1;
        alu_op = 4'd13;
        step();
        RST = 1'b0;
        check("rst_abort_stall", {31'd0, stall}, 32'd0);
        check_bubble("rst_abort");
        step();
        check("mfhi_after_rst", ex_alu_result, 32'd0);
        alu_op = 4'd14;
        step();
        check("mflo_after_rst", ex_alu_result, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
